counter_scheduler: RTL
======================

Name: counter_scheduler

Overview:
- Shares one CNT_W-bit up-counter among NUM_REQ requesters.
- Each requester asks for a timed interval of programmable length. The block arbitrates round-robin, loads and runs the shared counter for the winner, and returns a one-cycle done pulse.
- Sits between requesting blocks and the counter datapath; it owns the counter's clear and enable sequencing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 4, counter and interval-length width in bits.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- req  input  NUM_REQ  per-requester request level; held high until done or abort.
- len  input  NUM_REQ*CNT_W  flattened terminal counts; len[i*CNT_W +: CNT_W] belongs to requester i.
- gnt  output  NUM_REQ  one-hot grant; high while owner's interval runs.
- done  output  NUM_REQ  one-cycle pulse to owner when its interval completes.
- busy  output  1  high in RUN and DONE states.
- cnt  output  CNT_W  current counter value.

Behaviour:
- Reset (reset==0 at clock edge):
  - State -> IDLE.
  - gnt, done, busy, cnt, owner and latched target all cleared to 0.
  - RR pointer -> 0, so requester 0 has highest priority.
  - Reset wins over every other event, including mid-RUN; no done pulse is issued for the killed interval.
- State machine: IDLE, RUN, DONE (registered; all outputs registered).
- IDLE:
  - With req==0: stay in IDLE, cnt=0.
  - Otherwise, select the first asserted req[i] scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Latch owner=i and tgt=len[i] in the same cycle.
  - Next cycle: state RUN, gnt[i]=1, busy=1, cnt=0.
- RUN:
  - Each cycle, if cnt==tgt: next state DONE with cnt held.
  - Otherwise cnt increments by 1.
  - gnt[owner] therefore stays high for tgt+1 cycles, with cnt stepping 0..tgt.
  - cnt never exceeds tgt, so no wrap occurs; tgt=2^CNT_W-1 is legal and gives 2^CNT_W RUN cycles.
- DONE:
  - gnt=0, done[owner]=1 for exactly this cycle, busy=1.
  - ptr <= (owner+1) mod NUM_REQ.
  - Next state IDLE, cnt cleared to 0.
- Abort:
  - If req[owner]==0 in any RUN cycle: next state IDLE, gnt=0, cnt=0, no done pulse, ptr <= owner+1.
  - Abort takes priority over cnt==tgt in the same cycle.
- len[i] is sampled only at grant; changes during RUN are ignored.
- req of non-owners is ignored outside IDLE; those requests wait.
- Turnaround: at least one IDLE cycle between consecutive intervals. Minimum interval cost is tgt+3 cycles (IDLE+RUN+DONE).
- Requester protocol: drop req on the edge where done is seen. Because IDLE follows DONE, that request is not re-granted to the same requester.
- Invariants: gnt is one-hot or zero; done is one-hot or zero; gnt and done are never both high.

Test Plan:
- Hold reset=0 for 3 cycles with random req -> gnt=0, done=0, busy=0, cnt=0. Release reset with req=0 -> stays in IDLE.
- req=4'b0001, len0=3 -> gnt=0001 for 4 cycles with cnt=0,1,2,3; next cycle done=0001 and gnt=0; then IDLE with cnt=0.
- req=4'b1010 simultaneously, len1=1, len3=2:
  - Requester 1 served first: gnt 2 cycles, done.
  - Then IDLE, then requester 3: gnt 3 cycles, done.
  - Then ptr=0.
- len=0 for requester 2 -> gnt=0100 for exactly 1 cycle with cnt=0, then done=0100.
- Grant requester 0 with len=15, drop req0 when cnt=5 -> next cycle IDLE, gnt=0, cnt=0, no done pulse, ptr=1. With req=0011 pending, requester 1 is granted next.
- Assert reset=0 when cnt=7 of a len=15 interval -> next edge all outputs 0 and ptr=0; no done after release.

Source files
------------

// File: rtl/counter_scheduler_if.sv
// Request/grant bus between the requesting blocks and counter_scheduler.
//   req  : per-requester request level, held until done or abort
//   len  : flattened terminal counts, len[i*CNT_W +: CNT_W] is requester i
//   gnt  : one-hot grant, high while the owner's interval runs
//   done : one-cycle completion pulse to the owner
//   busy : scheduler is in RUN or DONE
//   cnt  : current shared counter value
// master = requester side, slave = scheduler side.
interface counter_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [CNT_W-1:0]         cnt;

  modport master (output req, len, input gnt, done, busy, cnt);
  modport slave  (input req, len, output gnt, done, busy, cnt);
endinterface

// File: rtl/counter_scheduler.sv
// Shares one CNT_W-bit up-counter among NUM_REQ requesters. A round-robin
// arbiter picks a requester in IDLE, the counter runs 0..len for it in RUN,
// and DONE pulses done to the owner. Dropping req mid-run aborts silently.
//   clock : system clock (rising edge)
//   reset : synchronous active-low reset
//   bus   : counter_scheduler_if slave modport (req/len in, gnt/done/busy/cnt out)
module counter_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  counter_scheduler_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt, ptr, ptr_nxt, pick, owner_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt, tgt, tgt_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt, done_q, done_nxt;
  logic               busy_q, busy_nxt, found;

  // (base + k) mod NUM_REQ without relying on NUM_REQ being a power of two
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Round-robin scan starting at ptr; first asserted request wins
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[rr_idx(ptr, k)]) begin
        found = 1'b1;
        pick  = rr_idx(ptr, k);
      end
    end
  end

  assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    tgt_nxt   = tgt;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt_q;
    gnt_nxt   = gnt_q;
    done_nxt  = '0;
    busy_nxt  = busy_q;
    unique case (state)
      IDLE: begin
        cnt_nxt  = '0;
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (found) begin
          state_nxt     = RUN;
          owner_nxt     = pick;
          tgt_nxt       = bus.len[pick*CNT_W +: CNT_W];
          gnt_nxt[pick] = 1'b1;
          busy_nxt      = 1'b1;
        end
      end
      RUN: begin
        // abort outranks completion in the same cycle
        if (!bus.req[owner]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = owner_inc;
        end else if (cnt_q == tgt) begin
          state_nxt       = DONE;
          gnt_nxt         = '0;
          done_nxt[owner] = 1'b1;
          busy_nxt        = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
        ptr_nxt   = owner_inc;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      owner  <= '0;
      tgt    <= '0;
      ptr    <= '0;
      cnt_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      tgt    <= tgt_nxt;
      ptr    <= ptr_nxt;
      cnt_q  <= cnt_nxt;
      gnt_q  <= gnt_nxt;
      done_q <= done_nxt;
      busy_q <= busy_nxt;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.cnt  = cnt_q;
endmodule
